// File: rtl/lcd_watch_display.sv
// rtl/lcd_watch_display.sv - HD44780 init sequence and continuous HH:MM:SS refresh driver
module lcd_watch_display #(
    parameter int TICK_DIV    = 100,
    parameter int POWER_TICKS = 20
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic [3:0] H10,
    input  logic [3:0] H1,
    input  logic [3:0] M10,
    input  logic [3:0] M1,
    input  logic [3:0] S10,
    input  logic [3:0] S1,
    output logic       LCD_E,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic [7:0] LCD_DATA,
    output logic       FRAME_DONE
);

    localparam int DIV_W  = $clog2(TICK_DIV);
    localparam int STEP_W = $clog2(POWER_TICKS + 1);

    typedef enum logic [3:0] {
        PWR_WAIT, FUNC_SET, DISP_ON, ENTRY_MODE, CLEAR, CLEAR_WAIT, SET_ADDR,
        WR_H10, WR_H1, WR_C1, WR_M10, WR_M1, WR_C2, WR_S10, WR_S1
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [23:0]        fb_q, fb_d;
    logic               e_q, e_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic               fd_q, fd_d;
    logic               wrap;
    logic               strobe;

    assign wrap = (div_q == DIV_W'(TICK_DIV - 1));

    function automatic logic [7:0] glyph(input logic [3:0] d);
        return (d <= 4'd9) ? {4'h3, d} : 8'h3F;
    endfunction

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q <= PWR_WAIT;
            div_q   <= '0;
            step_q  <= '0;
            fb_q    <= '0;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            step_q  <= step_d;
            fb_q    <= fb_d;
            e_q     <= e_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            fd_q    <= fd_d;
        end
    end

    // Every state lasts whole steps; only the two wait states need the step counter.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        div_d   = wrap ? '0 : div_q + 1'b1;
        if (wrap) begin
            step_d = '0;
            case (state_q)
                PWR_WAIT: begin
                    if (step_q == STEP_W'(POWER_TICKS - 1)) state_d = FUNC_SET;
                    else                                    step_d  = step_q + 1'b1;
                end
                CLEAR_WAIT: begin
                    if (step_q == STEP_W'(1)) state_d = SET_ADDR;
                    else                      step_d  = step_q + 1'b1;
                end
                WR_S1:   state_d = SET_ADDR;
                default: state_d = state_t'(state_q + 4'd1);
            endcase
        end
    end

    // Bus values are set for the state being entered, so E sees a full setup cycle.
    always_comb begin
        rs_d   = rs_q;
        data_d = data_q;
        fb_d   = fb_q;
        strobe = !(state_d inside {PWR_WAIT, CLEAR_WAIT});
        e_d    = strobe && (div_d != '0) && (div_d <= DIV_W'(TICK_DIV / 2));
        fd_d   = wrap && (state_q == WR_S1);
        if (wrap) begin
            if (state_d == SET_ADDR) fb_d = {H10, H1, M10, M1, S10, S1};
            case (state_d)
                FUNC_SET:   begin rs_d = 1'b0; data_d = 8'h38; end
                DISP_ON:    begin rs_d = 1'b0; data_d = 8'h0C; end
                ENTRY_MODE: begin rs_d = 1'b0; data_d = 8'h06; end
                CLEAR:      begin rs_d = 1'b0; data_d = 8'h01; end
                SET_ADDR:   begin rs_d = 1'b0; data_d = 8'h84; end
                WR_H10:     begin rs_d = 1'b1; data_d = glyph(fb_q[23:20]); end
                WR_H1:      begin rs_d = 1'b1; data_d = glyph(fb_q[19:16]); end
                WR_C1:      begin rs_d = 1'b1; data_d = 8'h3A; end
                WR_M10:     begin rs_d = 1'b1; data_d = glyph(fb_q[15:12]); end
                WR_M1:      begin rs_d = 1'b1; data_d = glyph(fb_q[11:8]); end
                WR_C2:      begin rs_d = 1'b1; data_d = 8'h3A; end
                WR_S10:     begin rs_d = 1'b1; data_d = glyph(fb_q[7:4]); end
                WR_S1:      begin rs_d = 1'b1; data_d = glyph(fb_q[3:0]); end
                default:    ;
            endcase
        end
    end

    assign LCD_E      = e_q;
    assign LCD_RS     = rs_q;
    assign LCD_RW     = 1'b0;
    assign LCD_DATA   = data_q;
    assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_lcd_watch_display.sv
// tb/tb_lcd_watch_display.sv - randomized scoreboard bench for lcd_watch_display
module tb_lcd_watch_display;

    localparam int TD = 100;
    localparam int PT = 20;

    logic       CLK = 1'b0;
    logic       RESETN = 1'b0;
    logic [3:0] h10 = 4'd1, h1 = 4'd2, m10 = 4'd3, m1 = 4'd4, s10 = 4'd5, s1 = 4'd6;
    logic       LCD_E, LCD_RS, LCD_RW, FRAME_DONE;
    logic [7:0] LCD_DATA;

    lcd_watch_display #(.TICK_DIV(TD), .POWER_TICKS(PT)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .H10(h10), .H1(h1), .M10(m10), .M1(m1), .S10(s10), .S1(s1),
        .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
        .LCD_DATA(LCD_DATA), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         rise;
    } exp_t;

    exp_t  sb[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    fd_n = 0;
    string font = "0123456789??????";

    always @(posedge CLK) cyc <= RESETN ? cyc + 1 : 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] ch(input logic [3:0] d);
        return 8'(font[int'(d)]);
    endfunction

    function automatic int frame_start(input int f);
        return (PT + 6 + 9 * f) * TD;
    endfunction

    task automatic push_init();
        logic [7:0] cmds [4];
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        for (int i = 0; i < 4; i++) sb.push_back('{1'b0, cmds[i], (PT + i) * TD + 1});
    endtask

    task automatic push_frame(input int f);
        logic [7:0] txt [8];
        txt = '{ch(h10), ch(h1), ":", ch(m10), ch(m1), ":", ch(s10), ch(s1)};
        sb.push_back('{1'b0, 8'h84, frame_start(f) + 1});
        for (int j = 0; j < 8; j++) sb.push_back('{1'b1, txt[j], frame_start(f) + (j + 1) * TD + 1});
    endtask

    task automatic wait_until(input int n);
        while (cyc < n) @(negedge CLK);
    endtask

    task automatic random_digits(input int maxv);
        h10 = 4'($urandom_range(0, maxv)); h1 = 4'($urandom_range(0, maxv));
        m10 = 4'($urandom_range(0, maxv)); m1 = 4'($urandom_range(0, maxv));
        s10 = 4'($urandom_range(0, maxv)); s1 = 4'($urandom_range(0, maxv));
    endtask

    // Monitor: every strobe pops one expectation; frame pulses are checked against the frame grid.
    initial begin
        exp_t cur;
        bit   in_strobe = 0;
        bit   unstable = 0;
        bit   fd_prev = 0;
        int   hi_cnt = 0;
        forever begin
            @(negedge CLK);
            if (!RESETN) begin
                in_strobe = 0; hi_cnt = 0; fd_prev = 0; fd_n = 0;
            end else begin
                if (LCD_E && !in_strobe) begin
                    in_strobe = 1; hi_cnt = 1; unstable = 0;
                    if (sb.size() == 0) begin
                        n_cmp++; n_fail++;
                        $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
                        cur = '{LCD_RS, LCD_DATA, cyc};
                    end else begin
                        cur = sb.pop_front();
                        check("strobe_cycle", cyc, cur.rise);
                        check("strobe_rs", int'(LCD_RS), int'(cur.rs));
                        check("strobe_data", int'(LCD_DATA), int'(cur.data));
                        check("strobe_rw", int'(LCD_RW), 0);
                    end
                end else if (LCD_E && in_strobe) begin
                    hi_cnt++;
                    if (LCD_RS !== cur.rs || LCD_DATA !== cur.data) unstable = 1;
                end else if (!LCD_E && in_strobe) begin
                    in_strobe = 0;
                    check("strobe_width", hi_cnt, TD / 2);
                    check("strobe_bus_stable", int'(unstable), 0);
                end
                if (FRAME_DONE) begin
                    check("frame_done_width", int'(fd_prev), 0);
                    check("frame_done_cycle", cyc, frame_start(fd_n + 1));
                    fd_n++;
                end
                fd_prev = FRAME_DONE;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        repeat (5) @(negedge CLK);
        check("reset_e", int'(LCD_E), 0);
        check("reset_rs", int'(LCD_RS), 0);
        check("reset_rw", int'(LCD_RW), 0);
        check("reset_data", int'(LCD_DATA), 0);
        check("reset_frame_done", int'(FRAME_DONE), 0);

        // Init plus frame 0 with 12:34:56.
        @(negedge CLK);
        RESETN = 1'b1;
        push_init();
        push_frame(0);

        // Change during WR_M10; only the next frame may show it.
        wait_until(frame_start(0) + 4 * TD + 50);
        {h10, h1, m10, m1, s10, s1} = {4'd2, 4'd3, 4'd5, 4'd9, 4'd5, 4'd9};
        push_frame(1);

        // Invalid BCD in first and last position, random valid elsewhere.
        wait_until(frame_start(1) + 450);
        random_digits(9);
        h10 = 4'hC;
        s1  = 4'hF;
        push_frame(2);

        for (int f = 2; f <= 5; f++) begin
            wait_until(frame_start(f) + 450);
            random_digits(15);
            push_frame(f + 1);
        end

        // Async reset while strobing WR_M1 of frame 6.
        wait_until(frame_start(6) + 5 * TD + 10);
        @(posedge CLK);
        #2;
        check("e_high_before_reset", int'(LCD_E), 1);
        RESETN = 1'b0;
        #1;
        check("async_reset_e", int'(LCD_E), 0);
        check("async_reset_rs", int'(LCD_RS), 0);
        check("async_reset_data", int'(LCD_DATA), 0);
        check("async_reset_frame_done", int'(FRAME_DONE), 0);
        sb.delete();
        repeat (3) @(negedge CLK);
        RESETN = 1'b1;
        push_init();
        push_frame(0);

        wait_until(frame_start(0) + 450);
        random_digits(15);
        push_frame(1);
        wait_until(frame_start(1) + 450);
        random_digits(15);
        push_frame(2);

        wait_until(frame_start(2) + 880);
        check("leftover_expectations", sb.size(), 0);
        check("frame_done_count", fd_n, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
